// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring divider, one quotient bit per clock, with
//            optional signed (truncating) mode and divide-by-zero detection.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [N-1:0]   r_dq;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_bmag;
    logic           r_qneg;
    logic           r_rneg;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;
    logic [N-1:0]   r_quot;
    logic [N-1:0]   r_remout;

    logic           w_sgn_act;
    logic           w_d_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_d_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_div_zero;
    logic [N:0]     w_shift;
    logic [N:0]     w_trial;
    logic           w_fits;

    assign w_sgn_act  = (SIGNED_EN != 1'b0) && signed_mode;
    assign w_d_neg    = w_sgn_act && dividend[N-1];
    assign w_b_neg    = w_sgn_act && divisor[N-1];
    // Magnitudes are unsigned N-bit, so negating -2^(N-1) yields 2^(N-1) exactly.
    assign w_d_mag    = w_d_neg ? -dividend : dividend;
    assign w_b_mag    = w_b_neg ? -divisor  : divisor;
    assign w_div_zero = (divisor == '0);

    // Partial remainder stays below the divisor, so the shifted value fits N+1 bits
    // and the trial's MSB is purely the borrow.
    assign w_shift = {r_rem, r_dq[N-1]};
    assign w_trial = w_shift - {1'b0, r_bmag};
    assign w_fits  = ~w_trial[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !w_div_zero) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq     <= '0;
            r_rem    <= '0;
            r_bmag   <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_quot   <= '0;
            r_remout <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            r_quot   <= '1;
                            r_remout <= dividend;
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_dq   <= w_d_mag;
                            r_bmag <= w_b_mag;
                            r_qneg <= w_d_neg ^ w_b_neg;
                            r_rneg <= w_d_neg;
                            r_rem  <= '0;
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
                    r_dq  <= {r_dq[N-2:0], w_fits};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quot   <= r_qneg ? -r_dq  : r_dq;
                    r_remout <= r_rneg ? -r_rem : r_rem;
                    r_dbz    <= 1'b0;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remout;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
